// File: rtl/seq_alu.sv
// seq_alu -- sequential ALU with a valid/ready request and result handshake.
//
// Single-cycle operations complete one cycle after acceptance. MUL, MULHU,
// DIVU and REMU run on an iterative unit that spends XLEN cycles in BUSY:
// shift-add for multiply, restoring division for divide. The iterative unit
// is only built when the macro SEQ_ALU_MULDIV_EN is defined. Without it,
// op codes 1100-1111 behave like any unlisted code and return 0.
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst        synchronous, active-high reset
//   in_valid   request valid
//   in_ready   block can accept a request (IDLE only)
//   op         4-bit operation code
//   src1/src2  XLEN-bit operands, captured on acceptance
//   out_valid  result valid (DONE only)
//   out_ready  consumer accepts the result
//   result     registered XLEN-bit result
//   Z          registered flag, set when result is all zeros
module seq_alu #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            Z
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] BUSY = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  logic [1:0]      state_r;
  logic [XLEN-1:0] alu_s;
  logic            mc_s;

  // Ready drops while reset is held so no request is seen during reset.
  assign in_ready  = (state_r == IDLE) && !rst;
  assign out_valid = (state_r == DONE);

  // Single-cycle operations, evaluated on the live inputs at acceptance.
  always_comb begin
    alu_s = '0;
    case (op)
      4'b0000: alu_s = src1 + src2;
      4'b0001: alu_s = src1 - src2;
      4'b0010: alu_s = src1 & src2;
      4'b0011: alu_s = src1 | src2;
      4'b0100: alu_s = {{(XLEN-1){1'b0}}, ($signed(src1) < $signed(src2))};
      4'b0101: alu_s = {{(XLEN-1){1'b0}}, (src1 < src2)};
      4'b0110: alu_s = src1 ^ src2;
      4'b1000: alu_s = src1 << src2[SHW-1:0];
      4'b1001: alu_s = $unsigned($signed(src1) >>> src2[SHW-1:0]);
      4'b1010: alu_s = src1 >> src2[SHW-1:0];
      default: alu_s = '0;
    endcase
  end

`ifdef SEQ_ALU_MULDIV_EN
  // Iterative unit state. acc_r is the running high half (multiply) or the
  // partial remainder (divide); lo_r is the shifting multiplier or the
  // dividend being turned into the quotient; b_r holds src2.
  logic [SHW-1:0]  cnt_r;
  logic [XLEN-1:0] acc_r;
  logic [XLEN-1:0] lo_r;
  logic [XLEN-1:0] b_r;
  logic [1:0]      op_r;
  logic [XLEN:0]   sum_s;
  logic [XLEN:0]   shifted_s;
  logic [XLEN:0]   trial_s;
  logic [XLEN-1:0] acc_n_s;
  logic [XLEN-1:0] lo_n_s;
  logic [XLEN-1:0] step_res_s;

  // Multi-cycle ops are the 11xx codes.
  always_comb begin
    mc_s = (op[3:2] == 2'b11);
  end

  // One iteration step; op_r[1] selects divide, op_r[0] selects the upper
  // register (MULHU high half, REMU remainder) as the final result.
  // A zero divisor never makes the trial negative, so the quotient fills
  // with ones and the remainder ends up equal to the dividend.
  always_comb begin
    sum_s     = {1'b0, acc_r} + (lo_r[0] ? {1'b0, b_r} : {(XLEN+1){1'b0}});
    shifted_s = {acc_r, lo_r[XLEN-1]};
    trial_s   = shifted_s - {1'b0, b_r};
    if (op_r[1]) begin
      acc_n_s = trial_s[XLEN] ? shifted_s[XLEN-1:0] : trial_s[XLEN-1:0];
      lo_n_s  = {lo_r[XLEN-2:0], ~trial_s[XLEN]};
    end else begin
      acc_n_s = sum_s[XLEN:1];
      lo_n_s  = {sum_s[0], lo_r[XLEN-1:1]};
    end
    step_res_s = op_r[0] ? acc_n_s : lo_n_s;
  end
`else
  // No iterative unit: every request completes in a single cycle.
  always_comb begin
    mc_s = 1'b0;
  end
`endif

  // Control FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      result  <= '0;
      Z       <= 1'b1;
`ifdef SEQ_ALU_MULDIV_EN
      cnt_r   <= '0;
      acc_r   <= '0;
      lo_r    <= '0;
      b_r     <= '0;
      op_r    <= 2'b00;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            if (mc_s) begin
              state_r <= BUSY;
`ifdef SEQ_ALU_MULDIV_EN
              cnt_r   <= '0;
              acc_r   <= '0;
              lo_r    <= src1;
              b_r     <= src2;
              op_r    <= op[1:0];
`endif
            end else begin
              state_r <= DONE;
              result  <= alu_s;
              Z       <= (alu_s == '0);
            end
          end
        end
`ifdef SEQ_ALU_MULDIV_EN
        BUSY: begin
          acc_r <= acc_n_s;
          lo_r  <= lo_n_s;
          cnt_r <= cnt_r + SHW'(1);
          if (cnt_r == SHW'(XLEN-1)) begin
            state_r <= DONE;
            result  <= step_res_s;
            Z       <= (step_res_s == '0);
          end
        end
`endif
        DONE: begin
          if (out_ready) begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (XLEN=32).
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        Z;

  int n_vec = 0;
  int n_err = 0;

  seq_alu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .src1(src1), .src2(src2), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .Z(Z)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Issue one request, scramble inputs after acceptance, measure latency,
  // check result/Z, then consume the result.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    @(negedge clk);
    chk1({tag, "_in_ready"}, in_ready, 1'b1);
    op = o; src1 = a; src2 = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; op = 4'b0000; src1 = 32'hDEADBEEF; src2 = 32'h12345678;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_result"}, result, exp);
    chk1({tag, "_Z"}, Z, (exp == 32'h0));
    chk1({tag, "_ready_done"}, in_ready, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk1({tag, "_valid_drop"}, out_valid, 1'b0);
    chk1({tag, "_ready_back"}, in_ready, 1'b1);
  endtask

  initial begin
    int lat;
    int seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = 4'b0000; src1 = 32'h0; src2 = 32'h0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result, 32'h0);
    chk1("rst_Z", Z, 1'b1);
    rst = 1'b0;
    #1;
    chk1("rst_release_ready", in_ready, 1'b1);

    // Single-cycle operations.
    run_op("add_wrap", 4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1);
    run_op("sub",      4'b0001, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1);
    run_op("and",      4'b0010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1);
    run_op("or",       4'b0011, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1);
    run_op("slt",      4'b0100, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1);
    run_op("sltu",     4'b0101, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1);
    run_op("xor",      4'b0110, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1);
    run_op("sll",      4'b1000, 32'h00000001, 32'h00000023, 32'h00000008, 1);
    run_op("sra",      4'b1001, 32'h80000000, 32'h00000024, 32'hF8000000, 1);
    run_op("srl",      4'b1010, 32'h80000000, 32'h00000024, 32'h08000000, 1);
    run_op("unl_0111", 4'b0111, 32'h12345678, 32'h11111111, 32'h00000000, 1);
    run_op("unl_1011", 4'b1011, 32'h12345678, 32'h11111111, 32'h00000000, 1);

`ifdef SEQ_ALU_MULDIV_EN
    run_op("mul",      4'b1100, 32'h00010000, 32'h00010003, 32'h00030000, 33);
    run_op("mulhu",    4'b1101, 32'h00010000, 32'h00010003, 32'h00000001, 33);
    run_op("divu",     4'b1110, 32'd100,      32'd7,        32'd14,       33);
    run_op("remu",     4'b1111, 32'd100,      32'd7,        32'd2,        33);
    run_op("divu_z",   4'b1110, 32'd12345,    32'd0,        32'hFFFFFFFF, 33);
    run_op("remu_z",   4'b1111, 32'd5,        32'd0,        32'd5,        33);
`else
    run_op("nomd_mul", 4'b1100, 32'h00010000, 32'h00010003, 32'h00000000, 1);
    run_op("nomd_div", 4'b1110, 32'd100,      32'd7,        32'h00000000, 1);
`endif

    // Backpressure: hold DONE for 5 cycles with a competing request.
    @(negedge clk);
    op = 4'b0010; src1 = 32'h0000FFFF; src2 = 32'h00FF00FF; in_valid = 1'b1;
    @(negedge clk);
    op = 4'b0000; src1 = 32'h00000001; src2 = 32'h00000001;
    for (int i = 0; i < 5; i++) begin
      chk1("bp_valid", out_valid, 1'b1);
      chk("bp_result", result, 32'h000000FF);
      chk1("bp_Z", Z, 1'b0);
      chk1("bp_ready", in_ready, 1'b0);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid === 1'b1) seen++;
      @(negedge clk);
    end
    chk("bp_not_accepted", 32'(seen), 32'd0);
    chk("bp_result_kept", result, 32'h000000FF);

    // Reset in the middle of an operation discards it.
    @(negedge clk);
`ifdef SEQ_ALU_MULDIV_EN
    op = 4'b1110; src1 = 32'd100; src2 = 32'd7; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
`else
    op = 4'b0011; src1 = 32'h00000F00; src2 = 32'h0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk1("mid_done_valid", out_valid, 1'b1);
`endif
    rst = 1'b1;
    #1;
    chk1("mid_rst_ready", in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk1("mid_out_valid", out_valid, 1'b0);
    chk("mid_result", result, 32'h0);
    chk1("mid_Z", Z, 1'b1);
    chk1("mid_in_ready", in_ready, 1'b1);
    seen = 0;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
      lat++;
    end
    chk("mid_no_pulse", 32'(seen), 32'd0);

    // Normal operation resumes after the discard.
    run_op("post_add", 4'b0000, 32'd2, 32'd3, 32'd5, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
